// File: rtl/gpio_bcd_ctrl_pkg.sv
// Shared types and helpers for the GPIO / BCD display controller.
// Holds the FSM state encoding, default sizes and the double-dabble digit adjust.
package gpio_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    localparam int BCD_DIGITS = 8;
    localparam int BCD_DATA_W = 32;
    localparam int BCD_SW_W   = 18;

    function automatic logic [3:0] bcd_adj(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/gpio_bcd_ctrl_if.sv
// Board/CPU-facing bundle of the controller: switches, GPIO words and BCD result.
// master = CPU/board side, slave = controller side.
interface gpio_bcd_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int DIGITS = 8,
    parameter int SW_W   = 18
);
    logic [SW_W-1:0]     sw_in;
    logic [31:0]         gpio_in_o;
    logic [DATA_W-1:0]   gpio_out_i;
    logic [4*DIGITS-1:0] bcd_o;
    logic                valid_o;
    logic                busy_o;
    logic                ovf_o;

    modport master (
        output sw_in, gpio_out_i,
        input  gpio_in_o, bcd_o, valid_o, busy_o, ovf_o
    );

    modport slave (
        input  sw_in, gpio_out_i,
        output gpio_in_o, bcd_o, valid_o, busy_o, ovf_o
    );
endinterface

// File: rtl/gpio_bcd_ctrl_sync2.sv
// Two-flop synchroniser for asynchronous level inputs, 2 clk edges of latency.
// No flow control: each bit is sampled every cycle.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/gpio_bcd_ctrl.sv
// Switch synchroniser plus iterative binary-to-BCD converter, one bit per cycle.
// Result DATA_W+1 cycles after capture; new gpio_out values are ignored while busy.
module gpio_bcd_ctrl
    import gpio_bcd_pkg::*;
#(
    parameter int DATA_W = BCD_DATA_W,
    parameter int DIGITS = BCD_DIGITS,
    parameter int SW_W   = BCD_SW_W
) (
    input  logic           clk,
    input  logic           rst,
    gpio_bcd_ctrl_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DATA_W);

    logic [SW_W-1:0] w_sw_sync;
    logic [BW-1:0]   w_adj;

    bcd_state_t      r_state;
    logic [DATA_W-1:0] r_src;
    logic [DATA_W-1:0] r_bin;
    logic [BW-1:0]   r_work;
    logic [CW-1:0]   r_cnt;
    logic            r_ovf;
    logic [BW-1:0]   r_bcd;
    logic            r_ovf_o;
    logic            r_valid;

    sync2 #(.W(SW_W)) u_sw_sync (
        .clk   (clk),
        .rst_n (rst),
        .i_d   (bus.sw_in),
        .o_q   (w_sw_sync)
    );

    assign bus.gpio_in_o = 32'(w_sw_sync);

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        assign w_adj[4*g +: 4] = bcd_adj(r_work[4*g +: 4]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_bin   <= '0;
            r_work  <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_bcd   <= '0;
            r_ovf_o <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.gpio_out_i != r_src) begin
                        r_src   <= bus.gpio_out_i;
                        r_bin   <= bus.gpio_out_i;
                        r_work  <= '0;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A set MSB after add-3 means the value no longer fits in DIGITS digits.
                    r_work <= {w_adj[BW-2:0], r_bin[DATA_W-1]};
                    r_bin  <= {r_bin[DATA_W-2:0], 1'b0};
                    r_ovf  <= r_ovf | w_adj[BW-1];
                    if (r_cnt == CW'(DATA_W - 1)) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    r_bcd   <= r_ovf ? {DIGITS{4'h9}} : r_work;
                    r_ovf_o <= r_ovf;
                    r_valid <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.bcd_o   = r_bcd;
    assign bus.ovf_o   = r_ovf_o;
    assign bus.valid_o = r_valid;
    assign bus.busy_o  = (r_state != IDLE);
endmodule

// File: tb/tb_gpio_bcd_ctrl.sv
// Scoreboard bench for gpio_bcd_ctrl: stimulus queues expected results, a monitor checks them.
module tb_gpio_bcd_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   busy_run = 0;

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
        int          at_cyc;
    } exp_t;

    exp_t exp_q[$];

    gpio_bcd_ctrl_if #(.DATA_W(32), .DIGITS(8), .SW_W(18)) bus ();

    gpio_bcd_ctrl #(.DATA_W(32), .DIGITS(8), .SW_W(18)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each valid pulse, checks data, timing and busy length.
    always @(negedge clk) begin
        if (bus.valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=1 required=0 (cyc=%0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("bcd_o", 64'(bus.bcd_o), 64'(e.bcd));
                chk("ovf_o", 64'(bus.ovf_o), 64'(e.ovf));
                chk("valid_cycle", 64'(cyc), 64'(e.at_cyc));
                chk("busy_len", 64'(busy_run), 64'd33);
            end
            busy_run = 0;
        end else if (!rst) begin
            busy_run = 0;
        end else if (bus.busy_o) begin
            busy_run++;
        end
    end

    task automatic push(input logic [31:0] bcd, input logic ovf, input int at);
        exp_t e;
        e.bcd = bcd;
        e.ovf = ovf;
        e.at_cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic convert(input logic [31:0] val, input logic [31:0] bcd, input logic ovf);
        @(negedge clk);
        bus.gpio_out_i = val;
        push(bcd, ovf, cyc + 34);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bcnt;
        bus.gpio_out_i = 32'd1234;
        bus.sw_in      = 18'h3FFFF;

        // Reset held with a pending value and all switches on.
        repeat (3) @(negedge clk);
        chk("rst_gpio_in", 64'(bus.gpio_in_o), 64'd0);
        chk("rst_bcd", 64'(bus.bcd_o), 64'd0);
        chk("rst_valid", 64'(bus.valid_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_ovf", 64'(bus.ovf_o), 64'd0);
        rst = 1'b1;
        push(32'h0000_1234, 1'b0, cyc + 34);
        wait_drain();

        convert(32'd1231, 32'h0000_1231, 1'b0);
        convert(32'd99999999, 32'h9999_9999, 1'b0);
        convert(32'd100000000, 32'h9999_9999, 1'b1);
        convert(32'hFFFF_FFFF, 32'h9999_9999, 1'b1);

        // Change the input ten shift cycles into a conversion.
        @(negedge clk);
        bus.gpio_out_i = 32'd23456789;
        n = cyc;
        push(32'h2345_6789, 1'b0, n + 34);
        push(32'h5959_5959, 1'b0, n + 68);
        while (cyc < n + 11) @(negedge clk);
        bus.gpio_out_i = 32'd59595959;
        wait_drain();
        bcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy_o) bcnt++;
        end
        chk("no_third_conv", 64'(bcnt), 64'd0);

        // Reset asserted just after shift edge E15.
        @(negedge clk);
        bus.gpio_out_i = 32'd9876543;
        n = cyc;
        while (cyc < n + 16) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_bcd", 64'(bus.bcd_o), 64'd0);
        chk("abort_valid", 64'(bus.valid_o), 64'd0);
        chk("abort_busy", 64'(bus.busy_o), 64'd0);
        chk("abort_ovf", 64'(bus.ovf_o), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        push(32'h0987_6543, 1'b0, cyc + 34);
        wait_drain();

        // Switch path latency and glitch behaviour.
        chk("sw_settled", 64'(bus.gpio_in_o), 64'h3FFFF);
        @(negedge clk);
        bus.sw_in = 18'h004CF;
        @(posedge clk);
        #1 chk("sw_edge1", 64'(bus.gpio_in_o), 64'h3FFFF);
        @(posedge clk);
        #1 chk("sw_edge2", 64'(bus.gpio_in_o), 64'h004CF);
        @(negedge clk);
        #1 bus.sw_in = 18'h0;
        #2 bus.sw_in = 18'h004CF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("sw_short_glitch", 64'(bus.gpio_in_o), 64'h004CF);
        end
        @(negedge clk);
        bus.sw_in = 18'h2AAAA;
        @(negedge clk);
        bus.sw_in = 18'h004CF;
        chk("sw_glitch_n1", 64'(bus.gpio_in_o), 64'h004CF);
        @(negedge clk);
        chk("sw_glitch_n2", 64'(bus.gpio_in_o), 64'h2AAAA);
        @(negedge clk);
        chk("sw_glitch_n3", 64'(bus.gpio_in_o), 64'h004CF);
        @(negedge clk);
        chk("sw_glitch_n4", 64'(bus.gpio_in_o), 64'h004CF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
